// File: rtl/round_if.sv
// Signal bundle between the evolution engine, the RAM bank multiplexer and the trigger source.
interface round_if #(
  parameter int unsigned W = 12
);
  logic             global_evo_en;
  logic             prev_status;
  logic             wden;
  logic [2*W-1:0]   round_read_pos;
  logic [2*W-1:0]   round_write_pos;
  logic             live;

  modport master (
    input  global_evo_en,
    input  prev_status,
    output wden,
    output round_read_pos,
    output round_write_pos,
    output live
  );

  modport slave (
    output global_evo_en,
    output prev_status,
    input  wden,
    input  round_read_pos,
    input  round_write_pos,
    input  live
  );
endinterface

// File: rtl/round.sv
// Game-of-Life evolution engine: one toroidal generation per trigger edge, 12 cycles per cell,
// reading the 9-cell neighbourhood through a 2-cycle-latency RAM and writing the new state.
module round #(
  parameter int unsigned M = 300,
  parameter int unsigned N = 400,
  parameter int unsigned W = 12
) (
  input  logic   clk,
  input  logic   rst,
  round_if.master bus
);
  localparam int unsigned AddrW = 2 * W;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic               evo_q, evo_d;
  logic [3:0]         slot_q, slot_d;
  logic [W-1:0]       row_q, row_d;
  logic [W-1:0]       col_q, col_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               centre_q, centre_d;
  logic               wden_q, wden_d;
  logic               live_q, live_d;
  logic [AddrW-1:0]   rd_pos_q, rd_pos_d;
  logic [AddrW-1:0]   wr_pos_q, wr_pos_d;

  // Neighbour idx 0..8 walks (dr,dc) row-major from (-1,-1) to (+1,+1) with toroidal wrap.
  function automatic logic [AddrW-1:0] nb_addr(input logic [W-1:0] r, input logic [W-1:0] c,
                                               input logic [3:0] idx);
    logic [W-1:0] nr;
    logic [W-1:0] nc;
    if (idx < 4'd3) begin
      nr = (r == '0) ? W'(M - 1) : r - 1'b1;
    end else if (idx < 4'd6) begin
      nr = r;
    end else begin
      nr = (r == W'(M - 1)) ? '0 : r + 1'b1;
    end
    case (idx)
      4'd0, 4'd3, 4'd6: nc = (c == '0) ? W'(N - 1) : c - 1'b1;
      4'd1, 4'd4, 4'd7: nc = c;
      default:          nc = (c == W'(N - 1)) ? '0 : c + 1'b1;
    endcase
    return AddrW'(nr) * AddrW'(N) + AddrW'(nc);
  endfunction

  always_comb begin
    state_d  = state_q;
    evo_d    = bus.global_evo_en;
    slot_d   = slot_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    centre_d = centre_q;
    wden_d   = 1'b0;
    live_d   = live_q;
    rd_pos_d = rd_pos_q;
    wr_pos_d = wr_pos_q;

    unique case (state_q)
      StIdle: begin
        if (bus.global_evo_en != evo_q) begin
          state_d  = StBusy;
          slot_d   = '0;
          row_d    = '0;
          col_d    = '0;
          cnt_d    = '0;
          centre_d = 1'b0;
          rd_pos_d = nb_addr('0, '0, 4'd0);
        end
      end
      StBusy: begin
        slot_d = slot_q + 4'd1;
        if (slot_q < 4'd8) begin
          rd_pos_d = nb_addr(row_q, col_q, slot_q + 4'd1);
        end
        // Data for the address shown in slot k arrives in slot k+2; the centre lands in slot 6.
        if (slot_q >= 4'd2 && slot_q <= 4'd10) begin
          if (slot_q == 4'd6) begin
            centre_d = bus.prev_status;
          end else begin
            cnt_d = cnt_q + {3'b000, bus.prev_status};
          end
        end
        if (slot_q == 4'd10) begin
          wden_d   = 1'b1;
          wr_pos_d = nb_addr(row_q, col_q, 4'd4);
          live_d   = (cnt_d == 4'd3) | (centre_q & (cnt_d == 4'd2));
        end
        if (slot_q == 4'd11) begin
          slot_d   = '0;
          cnt_d    = '0;
          centre_d = 1'b0;
          if (row_q == W'(M - 1) && col_q == W'(N - 1)) begin
            state_d = StIdle;
          end else begin
            if (col_q == W'(N - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            rd_pos_d = nb_addr(row_d, col_d, 4'd0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      evo_q    <= bus.global_evo_en;
      slot_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      centre_q <= 1'b0;
      wden_q   <= 1'b0;
      live_q   <= 1'b0;
      rd_pos_q <= '0;
      wr_pos_q <= '0;
    end else begin
      state_q  <= state_d;
      evo_q    <= evo_d;
      slot_q   <= slot_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      centre_q <= centre_d;
      wden_q   <= wden_d;
      live_q   <= live_d;
      rd_pos_q <= rd_pos_d;
      wr_pos_q <= wr_pos_d;
    end
  end

  assign bus.wden            = wden_q;
  assign bus.live            = live_q;
  assign bus.round_read_pos  = rd_pos_q;
  assign bus.round_write_pos = wr_pos_q;
endmodule

// File: tb/tb_round.sv
// Bench for round on a 5x5 torus: two-bank RAM model, Life reference model and write scoreboard.
module tb_round;
  localparam int M     = 5;
  localparam int N     = 5;
  localparam int W     = 4;
  localparam int Cells = M * N;

  typedef struct {
    int   addr;
    logic live;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evo = 1'b0;
  logic rd1 = 1'b0;
  logic prev = 1'b0;
  logic [24:0] bank [2];
  logic        load_en = 1'b0;
  logic        load_bank = 1'b0;
  logic [24:0] load_val = '0;
  int cyc = 0;

  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  exp_t q[$];
  logic [24:0] model;

  always #5 clk = ~clk;

  round_if #(.W(W)) bus ();
  assign bus.global_evo_en = evo;
  assign bus.prev_status   = prev;

  round #(.M(M), .N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Two-bank RAM: read bank follows the trigger level, 2-cycle read latency.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd1  <= (int'(bus.round_read_pos) < Cells) ? bank[evo][bus.round_read_pos] : 1'b0;
    prev <= rd1;
    if (load_en) begin
      bank[load_bank] <= load_val;
    end else if (bus.wden && int'(bus.round_write_pos) < Cells) begin
      bank[!evo][bus.round_write_pos] <= bus.live;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [24:0] next_gen(input logic [24:0] g);
    logic [24:0] nx;
    nx = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) n += int'(g[((r + dr + M) % M) * N + (c + dc + N) % N]);
          end
        end
        nx[r * N + c] = (n == 3) || (g[r * N + c] && n == 2);
      end
    end
    return nx;
  endfunction

  function automatic logic [24:0] cells3(input int a, input int b, input int c);
    logic [24:0] v;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic load(input logic b, input logic [24:0] v);
    load_bank = b;
    load_val  = v;
    load_en   = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Toggle the trigger and queue the full generation the reference model predicts.
  task automatic gen_toggle();
    logic [24:0] nxt;
    @(posedge clk);
    #1 evo = !evo;
    nxt = next_gen(model);
    for (int p = 0; p < Cells; p++) q.push_back('{addr: p, live: nxt[p], cyc: cyc + 12 + 12 * p});
    model = nxt;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    #1 chk("drain_timeout", q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wden"}, int'(bus.wden), 0);
    chk({tag, "_live"}, int'(bus.live), 0);
    chk({tag, "_rpos"}, int'(bus.round_read_pos), 0);
    chk({tag, "_wpos"}, int'(bus.round_write_pos), 0);
  endtask

  initial begin
    logic [24:0] horiz, vert, corners, rnd;
    int base;
    horiz   = cells3(11, 12, 13);
    vert    = cells3(7, 12, 17);
    corners = cells3(0, 4, 20);
    corners[24] = 1'b1;
    model = '0;

    fork
      forever begin
        @(negedge clk);
        if (bus.wden) begin
          pulses++;
          if (q.size() == 0) begin
            chk("unexpected_wden", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("wr_addr", int'(bus.round_write_pos), e.addr);
            chk("wr_live", int'(bus.live), int'(e.live));
            chk("wr_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    load(1'b0, '0);
    load(1'b1, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk_zero("idle100");

    // Blinker, both phases
    load(1'b1, horiz);
    model = horiz;
    gen_toggle();
    drain();
    chk("blinker_vert", int'(bank[0]), int'(vert));
    gen_toggle();
    drain();
    chk("blinker_horiz", int'(bank[1]), int'(horiz));

    // Block across the torus corners is a still life
    load(1'b1, corners);
    model = corners;
    gen_toggle();
    drain();
    chk("wrap_corners", int'(bank[0]), int'(corners));
    repeat (20) @(posedge clk);

    // Random soups
    for (int k = 0; k < 6; k++) begin
      rnd = 25'($urandom);
      load(!evo, rnd);
      model = rnd;
      gen_toggle();
      drain();
      chk("random_gen", int'(bank[!evo]), int'(model));
    end

    // Second edge while busy is dropped
    load(1'b0, '0);
    load(1'b1, '0);
    model = '0;
    base  = pulses;
    gen_toggle();
    repeat (50) @(posedge clk);
    #1 evo = !evo;
    drain();
    repeat (350) @(posedge clk);
    #1 chk("busy_pulses", pulses - base, Cells);

    // Reset mid-run at pulse 10
    base = pulses;
    gen_toggle();
    for (int i = 0; i < 300 && pulses < base + 11; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_pulse10", pulses - base, 11);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    #1 chk("no_wden_after_rst", pulses - base, 11);
    gen_toggle();
    drain();
    chk("restart_pulses", pulses - base, 11 + Cells);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
